// File: rtl/registru_pkg.sv
// Shared types and the one-bit shift/rotate step for registru_universal.
package registru_pkg;

   // Widest register the shared step function can serve.
   localparam int MAX_WIDTH = 64;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_LOAD = 3'b001,
      OP_INC  = 3'b010,
      OP_DEC  = 3'b011,
      OP_SHR  = 3'b100,
      OP_SHL  = 3'b101,
      OP_ROR  = 3'b110,
      OP_ROL  = 3'b111
   } op_e;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_e;

   typedef struct packed {
      logic [MAX_WIDTH-1:0] data;
      logic                 out_bit;
   } step_t;

   // Moves the low `width` bits of d by one position; bits above width are don't-care.
   function automatic step_t shift_step(input op_e op, input logic [MAX_WIDTH-1:0] d,
                                        input int width, input logic ser);
      step_t r;
      logic  fill;
      r.data    = d;
      r.out_bit = 1'b0;
      fill      = ser;
      case (op)
         OP_SHR, OP_ROR: begin
            r.out_bit = d[0];
            if (op == OP_ROR) fill = d[0];
            r.data = {1'b0, d[MAX_WIDTH-1:1]};
            for (int i = 0; i < MAX_WIDTH; i++) begin
               if (i == width - 1) r.data[i] = fill;
            end
         end
         OP_SHL, OP_ROL: begin
            for (int i = 0; i < MAX_WIDTH; i++) begin
               if (i == width - 1) r.out_bit = d[i];
            end
            if (op == OP_ROL) fill = r.out_bit;
            r.data = {d[MAX_WIDTH-2:0], fill};
         end
         default: r.data = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/registru_universal.sv
// Universal working register: load, inc/dec (wrap or saturate), and
// multi-bit shifts/rotates executed one bit per cycle behind READY.
module registru_universal
   import registru_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SAT   = 0,
   localparam int AW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic             OP_VALID,
   input  logic [2:0]       OP,
   input  logic [AW-1:0]    AMT,
   input  logic             SER_IN,
   input  logic [WIDTH-1:0] datain,
   output logic [WIDTH-1:0] dataout,
   output logic             READY,
   output logic             ZERO,
   output logic             CARRY
);

   logic [WIDTH-1:0]     data_q, data_d;
   logic                 carry_q, carry_d;
   state_e               state_q, state_d;
   logic [AW-1:0]        cnt_q, cnt_d;
   op_e                  op_q, op_d;
   logic                 ser_q, ser_d;

   logic [MAX_WIDTH-1:0] data_ext;
   op_e                  step_op;
   logic                 step_ser;
   step_t                step;
   logic [WIDTH:0]       sum;
   op_e                  op_in;

   assign op_in = op_e'(OP);

   // One step function serves both the accept edge and the SHIFT cycles.
   always_comb begin
      data_ext            = '0;
      data_ext[WIDTH-1:0] = data_q;
      step_op             = (state_q == S_IDLE) ? op_in  : op_q;
      step_ser            = (state_q == S_IDLE) ? SER_IN : ser_q;
      step                = shift_step(step_op, data_ext, WIDTH, step_ser);
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      data_d  = data_q;
      carry_d = carry_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      ser_d   = ser_q;
      sum     = {1'b0, data_q} + (WIDTH+1)'(1);
      case (state_q)
         S_IDLE: begin
            if (OP_VALID) begin
               case (op_in)
                  OP_NOP: ;
                  OP_LOAD: begin
                     data_d  = datain;
                     carry_d = 1'b0;
                  end
                  OP_INC: begin
                     if (SAT != 0 && &data_q) begin
                        carry_d = 1'b1;
                     end else begin
                        data_d  = sum[WIDTH-1:0];
                        carry_d = sum[WIDTH];
                     end
                  end
                  OP_DEC: begin
                     if (SAT != 0 && data_q == '0) begin
                        carry_d = 1'b1;
                     end else begin
                        data_d  = data_q - WIDTH'(1);
                        carry_d = (data_q == '0);
                     end
                  end
                  default: begin
                     if (AMT != '0) begin
                        data_d  = step.data[WIDTH-1:0];
                        carry_d = step.out_bit;
                        op_d    = op_in;
                        ser_d   = SER_IN;
                        if (AMT != AW'(1)) begin
                           state_d = S_SHIFT;
                           cnt_d   = AMT - AW'(1);
                        end
                     end
                  end
               endcase
            end
         end
         default: begin
            data_d  = step.data[WIDTH-1:0];
            carry_d = step.out_bit;
            cnt_d   = cnt_q - AW'(1);
            if (cnt_q == AW'(1)) state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         data_q  <= '0;
         carry_q <= 1'b0;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_NOP;
         ser_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         carry_q <= carry_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         ser_q   <= ser_d;
      end
   end

   assign dataout = data_q;
   assign CARRY   = carry_q;
   assign READY   = (state_q == S_IDLE);
   assign ZERO    = (data_q == '0);

endmodule

// File: tb/tb_registru_universal.sv
// Directed bench: a wrapping and a saturating instance share one stimulus stream.
module tb_registru_universal;
   import registru_pkg::*;

   logic       clk;
   logic       RESET;
   logic       OP_VALID;
   logic [2:0] OP;
   logic [2:0] AMT;
   logic       SER_IN;
   logic [7:0] datain;

   logic [7:0] dataout_w, dataout_s;
   logic       ready_w, ready_s, zero_w, zero_s, carry_w, carry_s;

   int checks = 0;
   int errors = 0;

   registru_universal #(.WIDTH(8), .SAT(0)) dut_w (
      .clk(clk), .RESET(RESET), .OP_VALID(OP_VALID), .OP(OP), .AMT(AMT),
      .SER_IN(SER_IN), .datain(datain), .dataout(dataout_w), .READY(ready_w),
      .ZERO(zero_w), .CARRY(carry_w)
   );

   registru_universal #(.WIDTH(8), .SAT(1)) dut_s (
      .clk(clk), .RESET(RESET), .OP_VALID(OP_VALID), .OP(OP), .AMT(AMT),
      .SER_IN(SER_IN), .datain(datain), .dataout(dataout_s), .READY(ready_s),
      .ZERO(zero_s), .CARRY(carry_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Holds one request for one clock; returns at the falling edge after the accept edge.
   task automatic issue(input op_e op, input logic [2:0] amt, input logic ser, input logic [7:0] din);
      OP_VALID = 1'b1;
      OP       = op;
      AMT      = amt;
      SER_IN   = ser;
      datain   = din;
      @(negedge clk);
      OP_VALID = 1'b0;
   endtask

   initial begin
      RESET    = 1'b1;
      OP_VALID = 1'b0;
      OP       = OP_NOP;
      AMT      = '0;
      SER_IN   = 1'b0;
      datain   = '0;
      @(negedge clk);
      RESET = 1'b0;
      check("rst_data", dataout_w, 8'h00);
      check("rst_ready", ready_w, 1'b1);

      // Reset pulse while idle
      issue(OP_LOAD, 0, 0, 8'h3C);
      check("load_3c", dataout_w, 8'h3C);
      check("load_3c_zero", zero_w, 1'b0);
      #2 RESET = 1'b1;
      #1;
      check("rst_idle_data", dataout_w, 8'h00);
      check("rst_idle_zero", zero_w, 1'b1);
      check("rst_idle_carry", carry_w, 1'b0);
      check("rst_idle_ready", ready_w, 1'b1);
      @(negedge clk);
      RESET = 1'b0;

      // Wrap vs saturate at the boundaries
      issue(OP_LOAD, 0, 0, 8'hFF);
      issue(OP_INC, 0, 0, 8'h00);
      check("w_inc_ff", dataout_w, 8'h00);
      check("w_inc_ff_carry", carry_w, 1'b1);
      check("w_inc_ff_zero", zero_w, 1'b1);
      check("s_inc_ff", dataout_s, 8'hFF);
      check("s_inc_ff_carry", carry_s, 1'b1);
      issue(OP_DEC, 0, 0, 8'h00);
      check("w_dec_00", dataout_w, 8'hFF);
      check("w_dec_00_carry", carry_w, 1'b1);
      check("s_dec_ff", dataout_s, 8'hFE);
      check("s_dec_ff_carry", carry_s, 1'b0);
      issue(OP_LOAD, 0, 0, 8'h00);
      issue(OP_DEC, 0, 0, 8'h00);
      check("s_dec_00", dataout_s, 8'h00);
      check("s_dec_00_carry", carry_s, 1'b1);
      check("w_dec_00b", dataout_w, 8'hFF);
      issue(OP_LOAD, 0, 0, 8'h10);
      issue(OP_INC, 0, 0, 8'h00);
      check("s_inc_10", dataout_s, 8'h11);
      check("s_inc_10_carry", carry_s, 1'b0);
      check("w_inc_10", dataout_w, 8'h11);

      // SHL by 2 then ROR by 3
      issue(OP_LOAD, 0, 0, 8'hC3);
      issue(OP_SHL, 2, 1, 8'h00);
      check("shl_step1", dataout_w, 8'h87);
      check("shl_step1_ready", ready_w, 1'b0);
      @(negedge clk);
      check("shl_done", dataout_w, 8'h0F);
      check("shl_done_carry", carry_w, 1'b1);
      check("shl_done_ready", ready_w, 1'b1);
      issue(OP_ROR, 3, 0, 8'h00);
      check("ror_step1", dataout_w, 8'h87);
      @(negedge clk);
      check("ror_step2", dataout_w, 8'hC3);
      @(negedge clk);
      check("ror_done", dataout_w, 8'hE1);
      check("ror_done_carry", carry_w, 1'b1);
      check("ror_done_ready", ready_w, 1'b1);

      // SHR by 7 with a LOAD request held high while busy
      issue(OP_LOAD, 0, 0, 8'h80);
      issue(OP_SHR, 7, 0, 8'h00);
      OP_VALID = 1'b1;
      OP       = OP_LOAD;
      datain   = 8'h55;
      for (int k = 2; k <= 7; k++) begin
         @(negedge clk);
         if (k == 4) begin
            check("shr_mid", dataout_w, 8'h08);
            check("shr_mid_ready", ready_w, 1'b0);
         end
      end
      OP_VALID = 1'b0;
      check("shr_done", dataout_w, 8'h01);
      check("shr_done_carry", carry_w, 1'b0);
      check("shr_done_ready", ready_w, 1'b1);

      // Reset aborts a shift in progress
      issue(OP_LOAD, 0, 0, 8'h80);
      issue(OP_SHR, 7, 0, 8'h00);
      @(negedge clk);
      check("abort_pre_ready", ready_w, 1'b0);
      RESET = 1'b1;
      #1;
      check("abort_data", dataout_w, 8'h00);
      check("abort_ready", ready_w, 1'b1);
      check("abort_carry", carry_w, 1'b0);
      @(negedge clk);
      RESET = 1'b0;
      issue(OP_INC, 0, 0, 8'h00);
      check("abort_inc", dataout_w, 8'h01);
      check("abort_inc_ready", ready_w, 1'b1);

      // AMT=0 rotate keeps data and CARRY
      issue(OP_LOAD, 0, 0, 8'hA5);
      issue(OP_ROL, 1, 0, 8'h00);
      check("rol1", dataout_w, 8'h4B);
      issue(OP_ROR, 1, 0, 8'h00);
      check("ror1", dataout_w, 8'hA5);
      check("ror1_carry", carry_w, 1'b1);
      issue(OP_ROL, 0, 0, 8'h00);
      check("rol0_data", dataout_w, 8'hA5);
      check("rol0_carry", carry_w, 1'b1);
      check("rol0_ready", ready_w, 1'b1);

      // Back-to-back accepts on consecutive edges
      issue(OP_LOAD, 0, 0, 8'h01);
      issue(OP_INC, 0, 0, 8'h00);
      issue(OP_INC, 0, 0, 8'h00);
      check("b2b_data", dataout_w, 8'h03);
      check("b2b_carry", carry_w, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/registru_universal.md
# registru_universal

Parametrised successor to the team's 4-bit load/inc/dec/shift register. It adds configurable width, rotate operations, multi-bit shifts executed one bit per cycle behind a ready handshake, optional saturating arithmetic and status flags. It serves as the general-purpose working register for datapath exercises that need counting, shifting and rotating on one storage element.

## Interface
- WIDTH, 8, register width in bits (≥2)
- SAT, 0, 1 = INC/DEC saturate at all-ones/zero; 0 = wrap modulo 2^WIDTH
- clk  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- OP_VALID  in  1  operation request; accepted only when READY=1
- OP  in  3  opcode (below)
- AMT  in  $clog2(WIDTH)  shift/rotate distance, 0..WIDTH-1
- SER_IN  in  1  fill bit for SHR/SHL
- datain  in  WIDTH  LOAD value
- dataout  out  WIDTH  register contents
- READY  out  1  1 = idle, can accept an operation
- ZERO  out  1  combinational (dataout == 0)
- CARRY  out  1  registered status of the last completed operation

## Operation
- Opcodes: 000 NOP, 001 LOAD, 010 INC, 011 DEC, 100 SHR, 101 SHL, 110 ROR, 111 ROL.
- FSM states: IDLE, SHIFT. READY=1 only in IDLE. OP_VALID is ignored while READY=0, with no queuing.
- NOP: no state change, CARRY held.
- LOAD: dataout←datain, CARRY←0.
- INC, wrap mode: +1 mod 2^WIDTH; CARRY←carry-out (1 only when all-ones→0).
- INC, SAT=1: all-ones holds; CARRY←1 on the saturating attempt.
- DEC, wrap mode: −1 mod 2^WIDTH; CARRY←borrow (1 only when 0→all-ones).
- DEC, SAT=1: 0 holds; CARRY←1 on the saturating attempt.
- Shifts/rotates, general: AMT and SER_IN are latched on accept. One bit moves per cycle. CARRY←the bit moved out in that cycle, so after completion it holds the last bit out.
- SHR: the latched SER_IN enters the MSB.
- SHL: the latched SER_IN enters the LSB.
- ROR/ROL: the bit moved out re-enters at the opposite end.
- AMT=0 shift/rotate: completes as NOP in one cycle; CARRY held; stays IDLE.
- AMT=1: one shift at the accept edge; stays IDLE.
- AMT=N>1: first shift at the accept edge, then SHIFT state with down-counter N−1. Each SHIFT cycle shifts once and decrements. Return to IDLE on the edge that performs the last shift.
- RESET asserted at any time, including mid-shift: operation aborted. dataout=0, CARRY=0, counter=0, state IDLE, READY=1 asynchronously.

## Timing
- Reset values: dataout=0, CARRY=0, READY=1, ZERO=1.
- LOAD/INC/DEC/NOP: result visible one cycle after the accept edge; back-to-back accepts every cycle.
- Shift/rotate by N≥1: final dataout visible after N rising edges from accept. READY low for N−1 cycles. The next op can be accepted on the edge that completes the last shift.
- ZERO follows dataout combinationally, with no added latency.

## Structure
- Package registru_pkg:
  - opcode enum op_e (OP_NOP…OP_ROL)
  - state enum state_e (S_IDLE, S_SHIFT)
  - function computing the single-bit shift/rotate result and the bit moved out, given WIDTH
- Single module, no sub-module. The one-bit shift step is the package function, reused by both the IDLE-accept and SHIFT paths.

## Test plan
- WIDTH=8, SAT=0: RESET pulse mid-idle -> dataout=0x00, ZERO=1, CARRY=0, READY=1. LOAD 0xFF, INC -> 0x00, CARRY=1, ZERO=1. DEC -> 0xFF, CARRY=1.
- WIDTH=8, SAT=1: LOAD 0xFF, INC -> 0xFF, CARRY=1. LOAD 0x00, DEC -> 0x00, CARRY=1. LOAD 0x10, INC -> 0x11, CARRY=0.
- LOAD 0xC3, SHL AMT=2 SER_IN=1 -> READY low 1 cycle, dataout 0x87 then 0x0F, CARRY=1. Then ROR AMT=3 on 0x0F -> 0xE1, CARRY=1.
- LOAD 0x80, SHR AMT=7 SER_IN=0: while READY=0 drive LOAD 0x55 -> ignored, final dataout=0x01 after 7 edges, CARRY=0.
- LOAD 0x80, SHR AMT=7; assert RESET 2 cycles after accept -> dataout=0x00, READY=1 immediately. After release, an INC is accepted -> 0x01.
- ROL AMT=0 on 0xA5 -> dataout 0xA5, CARRY unchanged, READY stays 1. Back-to-back LOAD 0x01, INC, INC on consecutive cycles -> 0x03.
